// File: rtl/std_div_arbiter_if.sv
// Request, response and divider channels of the shared-divider arbiter.
// The slave view belongs to the arbiter, the master view to its surroundings.
interface std_div_arbiter_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4
);
  localparam int ID_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_left;
  logic [NUM_REQ*WIDTH-1:0] req_right;

  logic             resp_valid;
  logic             resp_ready;
  logic [ID_W-1:0]  resp_id;
  logic [WIDTH-1:0] resp_quotient;
  logic [WIDTH-1:0] resp_remainder;
  logic             resp_div_by_zero;

  logic             div_go;
  logic [WIDTH-1:0] div_left;
  logic [WIDTH-1:0] div_right;
  logic             div_done;
  logic [WIDTH-1:0] div_quotient;
  logic [WIDTH-1:0] div_remainder;

  modport slave (
    input  req_valid, req_left, req_right, resp_ready,
    input  div_done, div_quotient, div_remainder,
    output req_ready, resp_valid, resp_id,
    output resp_quotient, resp_remainder, resp_div_by_zero,
    output div_go, div_left, div_right
  );

  modport master (
    output req_valid, req_left, req_right, resp_ready,
    output div_done, div_quotient, div_remainder,
    input  req_ready, resp_valid, resp_id,
    input  resp_quotient, resp_remainder, resp_div_by_zero,
    input  div_go, div_left, div_right
  );
endinterface

// File: rtl/std_div_arbiter.sv
// Round-robin front end sharing one multi-cycle divider among requesters.
// Divide-by-zero is answered locally without touching the divider.
module std_div_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4
) (
  input logic clk,
  input logic reset,
  std_div_arbiter_if.slave bus
);
  localparam int ID_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  g;
  logic [ID_W-1:0]  next_ptr;
  logic             found;
  logic [WIDTH-1:0] sel_left;
  logic [WIDTH-1:0] sel_right;

  logic             resp_valid;
  logic [ID_W-1:0]  resp_id;
  logic [WIDTH-1:0] resp_q;
  logic [WIDTH-1:0] resp_r;
  logic             resp_dz;
  logic             div_go;
  logic [WIDTH-1:0] div_l;
  logic [WIDTH-1:0] div_r;

  // Scan from rr_ptr upward; descending loop lets the nearest hit win.
  always_comb begin
    g     = '0;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      logic [ID_W-1:0] idx;
      idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (bus.req_valid[idx]) begin
        g     = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_left  = '0;
    sel_right = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (g == ID_W'(i)) begin
        sel_left  = bus.req_left[i*WIDTH +: WIDTH];
        sel_right = bus.req_right[i*WIDTH +: WIDTH];
      end
    end
  end

  assign next_ptr = (g == ID_W'(NUM_REQ - 1)) ? '0 : g + 1'b1;

  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && found)
      bus.req_ready[g] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_q     <= '0;
      resp_r     <= '0;
      resp_dz    <= 1'b0;
      div_go     <= 1'b0;
      div_l      <= '0;
      div_r      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            div_l   <= sel_left;
            div_r   <= sel_right;
            resp_id <= g;
            rr_ptr  <= next_ptr;
            if (sel_right == '0) begin
              resp_q     <= '1;
              resp_r     <= sel_left;
              resp_dz    <= 1'b1;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else begin
              resp_dz <= 1'b0;
              div_go  <= 1'b1;
              state   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          div_go <= 1'b0;
          state  <= WAIT;
        end
        WAIT: begin
          if (bus.div_done) begin
            resp_q     <= bus.div_quotient;
            resp_r     <= bus.div_remainder;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.resp_valid       = resp_valid;
  assign bus.resp_id          = resp_id;
  assign bus.resp_quotient    = resp_q;
  assign bus.resp_remainder   = resp_r;
  assign bus.resp_div_by_zero = resp_dz;
  assign bus.div_go           = div_go;
  assign bus.div_left         = div_l;
  assign bus.div_right        = div_r;
endmodule

// File: tb/tb_std_div_arbiter.sv
// Directed bench for std_div_arbiter with a 3-cycle behavioural divider.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_std_div_arbiter;
  localparam int WIDTH   = 32;
  localparam int NUM_REQ = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  std_div_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus();

  std_div_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  int go_count = 0;

  logic [WIDTH-1:0] lefts [NUM_REQ];
  logic [WIDTH-1:0] rights[NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_pack
    assign bus.req_left[i*WIDTH +: WIDTH]  = lefts[i];
    assign bus.req_right[i*WIDTH +: WIDTH] = rights[i];
  end

  logic [2:0]       m_cnt;
  logic [WIDTH-1:0] m_l, m_r, m_q, m_rem;
  logic             m_done;

  always @(posedge clk) begin
    if (reset) begin
      m_cnt  <= '0;
      m_done <= 1'b0;
      m_l    <= '0;
      m_r    <= '0;
      m_q    <= '0;
      m_rem  <= '0;
    end else begin
      m_done <= 1'b0;
      if (bus.div_go) begin
        m_cnt <= 3'd3;
        m_l   <= bus.div_left;
        m_r   <= bus.div_right;
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 3'd1;
        if (m_cnt == 3'd1) begin
          m_done <= 1'b1;
          m_q    <= m_l / m_r;
          m_rem  <= m_l % m_r;
        end
      end
    end
  end

  assign bus.div_done      = m_done;
  assign bus.div_quotient  = m_q;
  assign bus.div_remainder = m_rem;

  always @(negedge clk) if (bus.div_go) go_count++;

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Waits for the grant to requester i, then drops its valid.
  task automatic do_req(input int i, input logic [31:0] l,
                        input logic [31:0] r);
    int n;
    lefts[i] = l;
    rights[i] = r;
    bus.req_valid[i] = 1'b1;
    #1;
    for (n = 0; n < 50 && !bus.req_ready[i]; n++) @(negedge clk);
    checks++;
    if (!bus.req_ready[i]) begin
      failures++;
      $display("FAIL grant_timeout req=%0d got=0 exp=1", i);
    end
    @(negedge clk);
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic wait_resp(output logic [1:0] id, output logic [31:0] q,
                           output logic [31:0] r, output logic dz);
    int n;
    for (n = 0; n < 100 && !bus.resp_valid; n++) @(negedge clk);
    checks++;
    if (!bus.resp_valid) begin
      failures++;
      $display("FAIL resp_timeout got=0 exp=1");
    end
    id = bus.resp_id;
    q  = bus.resp_quotient;
    r  = bus.resp_remainder;
    dz = bus.resp_div_by_zero;
    if (bus.resp_ready) @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (bus.resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_resp_valid got=%0b exp=0", bus.resp_valid);
    end
    checks++;
    if (bus.req_ready !== 4'b0) begin
      failures++;
      $display("FAIL rst_req_ready got=%0b exp=0", bus.req_ready);
    end
    checks++;
    if (bus.div_go !== 1'b0 || bus.resp_div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL rst_go_dz got=%0b%0b exp=00",
               bus.div_go, bus.resp_div_by_zero);
    end
    checks++;
    if (bus.resp_id !== 2'd0 || bus.resp_quotient !== 32'd0 ||
        bus.resp_remainder !== 32'd0) begin
      failures++;
      $display("FAIL rst_resp got=%0h/%0h/%0h exp=0/0/0", bus.resp_id,
               bus.resp_quotient, bus.resp_remainder);
    end
    checks++;
    if (bus.div_left !== 32'd0 || bus.div_right !== 32'd0) begin
      failures++;
      $display("FAIL rst_div_ops got=%0h/%0h exp=0/0",
               bus.div_left, bus.div_right);
    end
    checks++;
    if (dut.rr_ptr !== 2'd0 || int'(dut.state) != 0) begin
      failures++;
      $display("FAIL rst_state got=%0d/%0d exp=0/0",
               dut.rr_ptr, int'(dut.state));
    end
  endtask

  task automatic test_single();
    logic [1:0] id; logic [31:0] q, r; logic dz;
    int go0;
    go0 = go_count;
    bus.resp_ready = 1'b1;
    do_req(0, 32'd100, 32'd7);
    wait_resp(id, q, r, dz);
    repeat (3) @(negedge clk);
    checks++;
    if (id !== 2'd0 || q !== 32'd14 || r !== 32'd2 || dz !== 1'b0) begin
      failures++;
      $display("FAIL single got=%0d/%0d/%0d/%0b exp=0/14/2/0", id, q, r, dz);
    end
    checks++;
    if (go_count - go0 != 1) begin
      failures++;
      $display("FAIL single_go_pulses got=%0d exp=1", go_count - go0);
    end
  endtask

  task automatic test_div_zero();
    logic [1:0] id; logic [31:0] q, r; logic dz;
    int go0;
    go0 = go_count;
    do_req(2, 32'd55, 32'd0);
    checks++;
    if (bus.resp_valid !== 1'b1) begin
      failures++;
      $display("FAIL dz_latency got=%0b exp=1", bus.resp_valid);
    end
    wait_resp(id, q, r, dz);
    repeat (5) @(negedge clk);
    checks++;
    if (id !== 2'd2 || q !== 32'hFFFF_FFFF || r !== 32'd55 || dz !== 1'b1) begin
      failures++;
      $display("FAIL dz_resp got=%0d/%0h/%0d/%0b exp=2/ffffffff/55/1",
               id, q, r, dz);
    end
    checks++;
    if (go_count != go0) begin
      failures++;
      $display("FAIL dz_no_go got=%0d exp=0", go_count - go0);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] id; logic [31:0] q, r; logic dz;
    int exp_g[8] = '{0, 1, 2, 3, 0, 1, 3, 1};
    int exp_q[4] = '{3, 6, 7, 6};
    int exp_r[4] = '{1, 2, 2, 4};
    apply_reset();
    lefts[0] = 32'd10; rights[0] = 32'd3;
    lefts[1] = 32'd20; rights[1] = 32'd3;
    lefts[2] = 32'd30; rights[2] = 32'd4;
    lefts[3] = 32'd40; rights[3] = 32'd6;
    bus.resp_ready = 1'b1;
    bus.req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 8; k++) begin
      int n;
      for (n = 0; n < 50 && bus.req_ready == 4'b0; n++) @(negedge clk);
      checks++;
      if (bus.req_ready !== 4'(1 << exp_g[k])) begin
        failures++;
        $display("FAIL rr_grant%0d got=%0b exp=%0b", k, bus.req_ready,
                 4'(1 << exp_g[k]));
      end
      @(negedge clk);
      if (k == 7) bus.req_valid = 4'b0000;
      wait_resp(id, q, r, dz);
      checks++;
      if (id !== 2'(exp_g[k]) || q !== 32'(exp_q[exp_g[k]]) ||
          r !== 32'(exp_r[exp_g[k]]) || dz !== 1'b0) begin
        failures++;
        $display("FAIL rr_resp%0d got=%0d/%0d/%0d/%0b exp=%0d/%0d/%0d/0", k,
                 id, q, r, dz, exp_g[k], exp_q[exp_g[k]], exp_r[exp_g[k]]);
      end
      if (k == 4) bus.req_valid = 4'b1010;
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] id; logic [31:0] q, r; logic dz;
    int n;
    lefts[2] = 32'd77; rights[2] = 32'd5;
    bus.resp_ready = 1'b0;
    bus.req_valid = 4'b0100;
    for (n = 0; n < 100 && !bus.resp_valid; n++) @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd2 ||
          bus.resp_quotient !== 32'd15 || bus.resp_remainder !== 32'd2 ||
          bus.req_ready !== 4'b0) begin
        failures++;
        $display("FAIL bp_hold%0d got=%0b/%0d/%0d/%0d/%0b exp=1/2/15/2/0", c,
                 bus.resp_valid, bus.resp_id, bus.resp_quotient,
                 bus.resp_remainder, bus.req_ready);
      end
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL bp_resume got=%0b/%0b exp=0/0100",
               bus.resp_valid, bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = 4'b0000;
    wait_resp(id, q, r, dz);
    checks++;
    if (id !== 2'd2 || q !== 32'd15 || r !== 32'd2) begin
      failures++;
      $display("FAIL bp_second got=%0d/%0d/%0d exp=2/15/2", id, q, r);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] id; logic [31:0] q, r; logic dz;
    logic seen;
    do_req(1, 32'd50, 32'd3);
    @(negedge clk);
    checks++;
    if (int'(dut.state) != 2) begin
      failures++;
      $display("FAIL mid_in_wait got=%0d exp=2", int'(dut.state));
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (int'(dut.state) != 0 || bus.resp_valid !== 1'b0 ||
        dut.rr_ptr !== 2'd0) begin
      failures++;
      $display("FAIL mid_reset got=%0d/%0b/%0d exp=0/0/0", int'(dut.state),
               bus.resp_valid, dut.rr_ptr);
    end
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.resp_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL mid_dropped got=1 exp=0");
    end
    do_req(0, 32'd9, 32'd2);
    wait_resp(id, q, r, dz);
    checks++;
    if (id !== 2'd0 || q !== 32'd4 || r !== 32'd1 || dz !== 1'b0) begin
      failures++;
      $display("FAIL mid_fresh got=%0d/%0d/%0d/%0b exp=0/4/1/0", id, q, r, dz);
    end
  endtask

  task automatic test_zero_max();
    logic [1:0] id; logic [31:0] q, r; logic dz;
    do_req(1, 32'd0, 32'd5);
    wait_resp(id, q, r, dz);
    checks++;
    if (id !== 2'd1 || q !== 32'd0 || r !== 32'd0 || dz !== 1'b0) begin
      failures++;
      $display("FAIL zero_dividend got=%0d/%0d/%0d/%0b exp=1/0/0/0",
               id, q, r, dz);
    end
    do_req(3, 32'hFFFF_FFFF, 32'd1);
    wait_resp(id, q, r, dz);
    checks++;
    if (id !== 2'd3 || q !== 32'hFFFF_FFFF || r !== 32'd0 || dz !== 1'b0) begin
      failures++;
      $display("FAIL max_dividend got=%0d/%0h/%0d/%0b exp=3/ffffffff/0/0",
               id, q, r, dz);
    end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      lefts[i] = '0;
      rights[i] = 32'd1;
    end
    test_reset();
    test_single();
    test_div_zero();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_zero_max();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/std_div_arbiter.md
Name: std_div_arbiter

Overview:
- Round-robin scheduler that shares one multi-cycle `std_div_pipe`-style divider among NUM_REQ requesters.
- Accepts one division at a time over per-requester valid/ready channels and sequences the divider's go/done protocol.
- Returns quotient, remainder and the requester ID on one shared response channel with backpressure.
- Handles divide-by-zero locally, without issuing to the divider.

Parameters:
- WIDTH, 32, operand and result width; must match the attached divider.
- NUM_REQ, 4, number of requesters, ≥2. ID_W = max(1, $clog2(NUM_REQ)) is a localparam.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high.
- req_left  input  NUM_REQ*WIDTH  dividends, requester i in bits [i*WIDTH +: WIDTH].
- req_right  input  NUM_REQ*WIDTH  divisors, same packing.
- resp_valid  output  1  response valid.
- resp_ready  input  1  response consumer ready.
- resp_id  output  ID_W  index of the requester the response belongs to.
- resp_quotient  output  WIDTH  quotient.
- resp_remainder  output  WIDTH  remainder.
- resp_div_by_zero  output  1  set when the divisor was 0.
- div_go  output  1  single-cycle start pulse to the divider.
- div_left  output  WIDTH  registered dividend to the divider.
- div_right  output  WIDTH  registered divisor to the divider.
- div_done  input  1  divider completion pulse.
- div_quotient  input  WIDTH  divider quotient; valid when div_done=1.
- div_remainder  input  WIDTH  divider remainder; valid when div_done=1.

Behaviour:
- Registered FSM with states IDLE, ISSUE, WAIT, RESP.
- Reset values:
  - State = IDLE, rr_ptr = 0.
  - req_ready, resp_valid, div_go, resp_div_by_zero = 0.
  - resp_id, resp_quotient, resp_remainder, div_left, div_right = 0.
- Reset mid-operation: the FSM returns to IDLE, any in-flight result is dropped, and no response is produced. The divider shares the same reset.
- IDLE:
  - Grant g = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - req_ready is combinational: one-hot on g in IDLE only when some req_valid is set; otherwise 0.
  - req_ready is 0 in every other state.
  - On acceptance (cycle T):
    - Latch left/right of g into div_left/div_right.
    - resp_id <= g; rr_ptr <= (g+1) mod NUM_REQ.
  - If right == 0:
    - resp_quotient <= all ones, resp_remainder <= left, resp_div_by_zero <= 1.
    - Next state RESP; resp_valid is high from T+1.
  - Else: resp_div_by_zero <= 0 and next state ISSUE.
- ISSUE: div_go = 1 for exactly this cycle (T+1); next state WAIT. div_go is 0 in every other state.
- WAIT:
  - Hold div_left/div_right stable.
  - On div_done = 1, capture div_quotient/div_remainder into the resp_* registers; next state RESP.
  - The response is visible the cycle after div_done.
  - No timeout.
- RESP:
  - resp_valid = 1; all resp_* outputs are held stable until resp_valid && resp_ready.
  - On that cycle, next state IDLE. A new request is accepted one cycle later, not in the same cycle.
- div_done outside WAIT is ignored.
- Requester side:
  - Requesters must hold req_valid and operands until accepted.
  - Deasserting req_valid before acceptance is permitted; the arbiter simply skips that requester.
- Fairness:
  - A continuously valid requester is granted within NUM_REQ acceptances.
  - rr_ptr only advances on acceptance.
- Throughput: at most one outstanding division. The minimum non-zero-divisor turnaround is accept → ISSUE → divider latency → RESP → IDLE.
- Arithmetic is unsigned throughout. left == 0 with a non-zero right goes through the divider as a normal issue; the expected result is q=0, r=0.

Test Plan:
- Single request: req0 issues 100/7 with resp_ready=1 → exactly one div_go pulse; response resp_id=0, q=14, r=2, div_by_zero=0.
- Divide by zero: req2 issues 55/0 → no div_go; resp_valid at T+1 with id=2, q=0xFFFFFFFF, r=55, div_by_zero=1.
- Round-robin: all 4 requesters valid continuously with distinct operands (10/3, 20/3, 30/4, 40/6) → grants in order 0,1,2,3,0.
  - Check each q/r: 3/1, 6/2, 7/2, 6/4.
  - Then only req1 and req3 valid with rr_ptr=1 → grants 1,3,1.
- Backpressure: hold resp_ready=0 for 5 cycles after resp_valid → outputs stable, req_ready stays 0 although req_valid is high; accept resumes in the cycle after the handshake.
- Reset mid-operation: assert reset in WAIT → next cycle state IDLE, resp_valid=0, rr_ptr=0, no response for the dropped request; a fresh 9/2 request then yields q=4, r=1.
- Zero dividend and max values: 0/5 → q=0, r=0, div_by_zero=0. 0xFFFFFFFF/1 → q=0xFFFFFFFF, r=0.
